// File: rtl/leg_io_pkg.sv
// Shared defaults and sizing helper for the LEG architectural I/O port.
package leg_io_pkg;

  localparam int LEG_WIDTH = 8;
  localparam int LEG_DEPTH = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/leg_byte_fifo.sv
// Register-array FIFO; simultaneous push and pop are legal, even when full.
module leg_byte_fifo
  import leg_io_pkg::*;
#(
  parameter int DEPTH = LEG_DEPTH,
  parameter int WIDTH = LEG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/leg_io_port.sv
// Environment endpoint of the LEG core I/O channel: input/output FIFOs with
// drop-on-full, zero-on-empty read data and sticky underflow/overflow flags.
module leg_io_port
  import leg_io_pkg::*;
#(
  parameter int DEPTH = LEG_DEPTH,
  parameter int WIDTH = LEG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arch_input_enable,
  output logic [WIDTH-1:0]         arch_input_value,
  input  logic                     arch_output_enable,
  input  logic [WIDTH-1:0]         arch_output_value,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [cnt_w(DEPTH)-1:0]  in_count,
  output logic [cnt_w(DEPTH)-1:0]  out_count,
  output logic                     underflow,
  output logic                     overflow,
  input  logic                     clr_err
);

  logic             in_full_s, in_empty_s, out_full_s, out_empty_s;
  logic             in_push_s, in_pop_s, out_push_s, out_pop_s;
  logic [WIDTH-1:0] in_head_s;
  logic             underflow_r, overflow_r;

  assign in_ready   = !in_full_s;
  assign out_valid  = !out_empty_s;
  assign in_push_s  = in_valid && !in_full_s;
  assign in_pop_s   = arch_input_enable && !in_empty_s;
  assign out_pop_s  = out_ready && !out_empty_s;
  // A drain in the same cycle frees the slot the core's byte needs.
  assign out_push_s = arch_output_enable && (!out_full_s || out_pop_s);
  assign underflow  = underflow_r;
  assign overflow   = overflow_r;

  leg_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push_s),
    .din   (in_data),
    .pop   (in_pop_s),
    .dout  (in_head_s),
    .full  (in_full_s),
    .empty (in_empty_s),
    .count (in_count)
  );

  leg_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push_s),
    .din   (arch_output_value),
    .pop   (out_pop_s),
    .dout  (out_data),
    .full  (out_full_s),
    .empty (out_empty_s),
    .count (out_count)
  );

  // Core sees zero rather than stale storage when nothing is queued.
  always_comb begin
    arch_input_value = WIDTH'(0);
    if (!in_empty_s) begin
      arch_input_value = in_head_s;
    end else begin
      arch_input_value = WIDTH'(0);
    end
  end

  // Sticky error flags; clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (arch_input_enable && in_empty_s) begin
        underflow_r <= 1'b1;
      end
      if (arch_output_enable && !out_push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule
